// File: rtl/hwalu_result_drain.sv
`default_nettype none
// hwalu_result_drain: buffers {opcode, result} pairs and streams the selected 16-bit lanes, highest first.
// Optional HWALU_DRAIN_ZSKIP_EN: each entry starts at its highest non-zero selected lane.
module hwalu_result_drain #(
    parameter int DEPTH  = 4,
    parameter int LANE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid,
    input  logic [63:0]       result,
    input  logic [3:0]        opcode,
    output logic              res_ready,
    output logic              out_valid,
    output logic [LANE_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        out_mode,
    input  logic              out_ready,
    output logic              err_ovf,
    output logic              err_mode
);
    localparam int             PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT   = (PTR_W+1)'(1);
    localparam logic [0:0]     ST_IDLE   = 1'b0;
    localparam logic [0:0]     ST_STREAM = 1'b1;

    logic [67:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic [63:0]      data_q, data_d;
    logic [1:0]       lane_q, lane_d;
    logic [1:0]       mode_q, mode_d;
    logic             err_ovf_q, err_mode_q, err_mode_d;

    logic        w_push, w_pop, w_hs, w_last, w_empty, w_head_rsv;
    logic [67:0] w_head;
    logic [1:0]  w_start;

    assign res_ready  = (count_q != FULL_CNT);
    assign w_empty    = (count_q == '0);
    assign w_push     = res_valid && res_ready;
    assign out_valid  = (state_q == ST_STREAM);
    assign w_last     = (lane_q == 2'd0);
    assign w_hs       = out_valid && out_ready;
    // A finishing beat hands straight over to the next head so entries stream without a bubble.
    assign w_pop      = !w_empty && ((state_q == ST_IDLE) || (w_hs && w_last));
    assign w_head     = mem_q[rd_ptr_q];
    assign w_head_rsv = (w_head[67:66] == 2'b11);

    assign out_data = data_q[32'(lane_q) * LANE_W +: LANE_W];
    assign out_last = out_valid && w_last;
    assign out_mode = mode_q;
    assign err_ovf  = err_ovf_q;
    assign err_mode = err_mode_q;

`ifdef HWALU_DRAIN_ZSKIP_EN
    always_comb begin
        w_start = 2'd0;
        for (int l = 1; l < 4; l++) begin
            if ((l <= int'(w_head[65:64])) && (w_head[l*16 +: 16] != 16'h0000)) begin
                w_start = 2'(l);
            end
        end
    end
`else
    assign w_start = w_head[65:64];
`endif

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        lane_d     = lane_q;
        mode_d     = mode_q;
        err_mode_d = err_mode_q;
        if (w_hs) begin
            if (!w_last) begin
                lane_d = lane_q - 2'd1;
            end else begin
                state_d = ST_IDLE;
            end
        end
        if (w_pop) begin
            if (w_head_rsv) begin
                err_mode_d = 1'b1;
                state_d    = ST_IDLE;
            end else begin
                data_d  = w_head[63:0];
                lane_d  = w_start;
                mode_d  = w_head[67:66];
                state_d = ST_STREAM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {opcode, result};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            data_q     <= '0;
            lane_q     <= '0;
            mode_q     <= '0;
            err_ovf_q  <= 1'b0;
            err_mode_q <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            state_q    <= state_d;
            data_q     <= data_d;
            lane_q     <= lane_d;
            mode_q     <= mode_d;
            err_ovf_q  <= err_ovf_q | (res_valid & ~res_ready);
            err_mode_q <= err_mode_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hwalu_result_drain.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for hwalu_result_drain: queue-based reference model checked every cycle plus directed literal cases.
module tb_hwalu_result_drain;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        res_valid = 1'b0;
    logic [63:0] result = '0;
    logic [3:0]  opcode = '0;
    logic        out_ready = 1'b0;
    logic        res_ready, out_valid, out_last, err_ovf, err_mode;
    logic [15:0] out_data;
    logic [1:0]  out_mode;

    hwalu_result_drain #(.DEPTH(DEPTH), .LANE_W(16)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .result(result), .opcode(opcode),
        .res_ready(res_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_mode(out_mode), .out_ready(out_ready), .err_ovf(err_ovf), .err_mode(err_mode)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: entries waiting in the buffer, and the beats still owed for the current entry.
    logic [67:0] m_fifo [$];
    logic [15:0] m_beats[$];
    logic [1:0]  m_mode;
    bit          m_ovf, m_emode;

    task automatic model_step();
        bit          rdy, cur, hs, pop;
        logic [67:0] head;
        int          start;
        if (!rst) begin
            m_fifo.delete();
            m_beats.delete();
            m_mode  = 2'd0;
            m_ovf   = 1'b0;
            m_emode = 1'b0;
            return;
        end
        rdy = (m_fifo.size() < DEPTH);
        cur = (m_beats.size() > 0);
        hs  = cur && out_ready;
        pop = (m_fifo.size() > 0) && (!cur || (hs && m_beats.size() == 1));
        if (res_valid && !rdy) m_ovf = 1'b1;
        if (hs) void'(m_beats.pop_front());
        if (pop) begin
            head = m_fifo.pop_front();
            if (head[67:66] == 2'b11) begin
                m_emode = 1'b1;
            end else begin
                m_mode = head[67:66];
                start  = int'(head[65:64]);
`ifdef HWALU_DRAIN_ZSKIP_EN
                while (start > 0 && head[start*16 +: 16] == 16'h0000) start--;
`endif
                for (int l = start; l >= 0; l--) m_beats.push_back(head[l*16 +: 16]);
            end
        end
        if (res_valid && rdy) m_fifo.push_back({opcode, result});
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("res_ready", res_ready, (m_fifo.size() < DEPTH));
        chk("out_valid", out_valid, (m_beats.size() > 0));
        chk("err_ovf", err_ovf, m_ovf);
        chk("err_mode", err_mode, m_emode);
        if (out_valid && m_beats.size() > 0) begin
            chk("out_data", out_data, m_beats[0]);
            chk("out_last", out_last, (m_beats.size() == 1));
            chk("out_mode", out_mode, m_mode);
        end
    end

    logic [15:0] exp_d[$];
    bit          exp_l[$];
    logic [1:0]  exp_m[$];

    task automatic exp_beat(input logic [15:0] d, input bit l, input logic [1:0] m);
        exp_d.push_back(d);
        exp_l.push_back(l);
        exp_m.push_back(m);
    endtask

    // Waits (bounded) for each expected beat; gaps = idle sampled cycles before/between beats.
    task automatic expect_beats(input string name, output int gaps);
        int n;
        int w;
        n    = exp_d.size();
        gaps = 0;
        for (int i = 0; i < n; i++) begin
            w = 0;
            @(negedge clk);
            while (!out_valid && w < 30) begin
                w++;
                @(negedge clk);
            end
            if (!out_valid) begin
                chk({name, "_timeout"}, out_valid, 1'b1);
                break;
            end
            gaps += w;
            chk({name, "_data"}, out_data, exp_d[i]);
            chk({name, "_last"}, out_last, exp_l[i]);
            chk({name, "_mode"}, out_mode, exp_m[i]);
        end
        exp_d.delete();
        exp_l.delete();
        exp_m.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          gaps;
    logic [15:0] held;

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_mode", out_mode, 2'b00);
        chk("rst_res_ready", res_ready, 1'b1);
        chk("rst_err_ovf", err_ovf, 1'b0);
        chk("rst_err_mode", err_mode, 1'b0);
        #2 rst = 1'b1;
        out_ready = 1'b1;

        // Muladd, four lanes
        step();
        res_valid = 1'b1; result = 64'h3fe8_07ff_0083_fc03; opcode = 4'b0011;
        step();
        res_valid = 1'b0;
        exp_beat(16'h3fe8, 0, 2'b00); exp_beat(16'h07ff, 0, 2'b00);
        exp_beat(16'h0083, 0, 2'b00); exp_beat(16'hfc03, 1, 2'b00);
        expect_beats("muladd", gaps);
        chk("muladd_latency_gaps", gaps, 1);

        // Dot then complex, back to back
        step();
        res_valid = 1'b1; result = 64'h0000_0000_0000_0880; opcode = 4'b0100;
        step();
        result = 64'h0102_6000_fffc_c000; opcode = 4'b1011;
        step();
        res_valid = 1'b0;
        exp_beat(16'h0880, 1, 2'b01);
        exp_beat(16'h0102, 0, 2'b10); exp_beat(16'h6000, 0, 2'b10);
        exp_beat(16'hfffc, 0, 2'b10); exp_beat(16'hc000, 1, 2'b10);
        expect_beats("b2b", gaps);
        chk("b2b_gaps", gaps, 0);

        // Zero-lane skip
        step();
        res_valid = 1'b1; result = 64'h0000_0000_0003_fc01; opcode = 4'b0011;
        step();
        res_valid = 1'b0;
`ifndef HWALU_DRAIN_ZSKIP_EN
        exp_beat(16'h0000, 0, 2'b00); exp_beat(16'h0000, 0, 2'b00);
`endif
        exp_beat(16'h0003, 0, 2'b00); exp_beat(16'hfc01, 1, 2'b00);
        expect_beats("zskip", gaps);

        // Backpressure and overflow
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            res_valid = 1'b1;
            result    = {32'h0, 16'hA000 + 16'(i), 16'hB000 + 16'(i)};
            opcode    = 4'b0001;
            step();
        end
        res_valid = 1'b0;
        @(negedge clk);
        chk("bp_res_ready", res_ready, 1'b0);
        chk("bp_err_ovf", err_ovf, 1'b1);
        held = out_data;
        chk("bp_first_beat", out_data, 16'hA000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_valid", out_valid, 1'b1);
            chk("bp_stall_data", out_data, held);
        end
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_beat(16'hA000 + 16'(i), 0, 2'b00);
            exp_beat(16'hB000 + 16'(i), 1, 2'b00);
        end
        expect_beats("bp_drain", gaps);
        chk("bp_drain_gaps", gaps, 0);

        // Reserved mode entry is discarded
        step();
        res_valid = 1'b1; result = 64'hdead_beef_cafe_f00d; opcode = 4'b1100;
        step();
        result = 64'h5555_6666_7777_1234; opcode = 4'b0000;
        step();
        res_valid = 1'b0;
        exp_beat(16'h1234, 1, 2'b00);
        expect_beats("rsv", gaps);
        chk("rsv_err_mode", err_mode, 1'b1);

        // Reset during the second beat
        step();
        res_valid = 1'b1; result = 64'h1111_2222_3333_4444; opcode = 4'b1011;
        step();
        res_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_beat1", out_data, 16'h1111);
        @(negedge clk);
        chk("mid_beat2", out_data, 16'h2222);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 16'h0000);
        chk("mid_rst_mode", out_mode, 2'b00);
        chk("mid_rst_ovf", err_ovf, 1'b0);
        chk("mid_rst_emode", err_mode, 1'b0);
        chk("mid_rst_ready", res_ready, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", out_valid, 1'b0);
        end
        step();
        res_valid = 1'b1; result = 64'h0000_0000_abcd_0042; opcode = 4'b0001;
        step();
        res_valid = 1'b0;
        exp_beat(16'habcd, 0, 2'b00); exp_beat(16'h0042, 1, 2'b00);
        expect_beats("post_rst", gaps);
        chk("post_rst_gaps", gaps, 1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            res_valid = ($urandom_range(0, 1) == 1);
            for (int l = 0; l < 4; l++) begin
                result[l*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0000;
            end
            opcode    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        step();
        res_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) step();
        chk("final_drained", out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hwalu_result_drain.md
# hwalu_result_drain

Downstream stage of `hwalu`. Captures each 64-bit `result` with the `opcode` it was produced under, buffers it in a small FIFO, and serialises the selected 16-bit lanes onto a valid/ready stream. `opcode[1:0]` selects the highest lane to emit: 11 = [63:48], 10 = [47:32], 01 = [31:16], 00 = [15:0]. It decouples the fixed-rate multiplier from a back-pressured consumer such as a bus writer or result RAM.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `LANE_W`, 16: output beat width; fixed at 16 for this revision.

- `clk`  in  1  single clock; rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `res_valid`  in  1  `result`/`opcode` valid this cycle.
- `result`  in  64  `hwalu` result.
- `opcode`  in  4  `hwalu` opcode, aligned with `result`.
- `res_ready`  out  1  FIFO can accept; equals `count != DEPTH` (registered count).
- `out_valid`  out  1  beat valid.
- `out_data`  out  16  beat payload.
- `out_last`  out  1  final beat of the entry (lane 0).
- `out_mode`  out  2  `opcode[3:2]` of the streaming entry.
- `out_ready`  in  1  consumer accepts beat.
- `err_ovf`  out  1  sticky: `res_valid` seen while `res_ready`=0.
- `err_mode`  out  1  sticky: an entry with mode 11 was popped.

## Operation
- **Push:** occurs when `res_valid && res_ready`; stores `{opcode, result}`. `res_valid` while full is dropped and sets `err_ovf`.
- **Circular FIFO:**
  - write/read pointers of log2(DEPTH) bits wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - A simultaneous push and pop keeps count unchanged.
  - A push is never accepted on the cycle the FIFO is full, even if a pop also occurs, because ready is taken from the registered count.
- **FSM `IDLE` / `STREAM`:**
  - IDLE, FIFO non-empty: pop head into a 64-bit shift register. Load lane counter with `opcode[1:0]` and latch `out_mode`. Go to STREAM.
  - If the head mode is 11: discard the entry, set `err_mode`, stay in IDLE.
  - STREAM: `out_data` = lane[counter]; `out_last` = (counter==0).
  - On `out_valid && out_ready`: if not last, decrement counter. If last and FIFO non-empty, pop the next head on the same edge (no bubble). If last and FIFO empty, go to IDLE.
- **Beat order:** highest selected lane first, down to lane 0. Beats per entry = `opcode[1:0]`+1.
- **Payload:** no arithmetic on data; lanes are emitted unmodified.
- **Output stability:** `out_data`/`out_last`/`out_mode` hold stable while `out_valid && !out_ready`.
- **Error flags:** cleared only by reset.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_last`=0, `out_mode`=0, `res_ready`=1, `err_ovf`=0, `err_mode`=0.
  - FIFO pointers and count = 0; FSM = IDLE.
- **Reset assertion mid-stream:** outputs go to their reset values immediately (asynchronous). Buffered entries are lost.
- **Latency:** push at edge N gives `out_valid`=1 after edge N+1 with the first beat.
- **Throughput:** one beat per cycle while `out_ready`=1.
  - A 4-lane entry occupies 4 cycles.
  - Sustained input is 1 result per `opcode[1:0]`+1 cycles.
- **`res_ready` deassertion:** `res_ready` falls the cycle after the push that fills the FIFO. It rises the cycle after the first pop from full.
- **`out_valid` with `out_ready` low:** `out_valid` never deasserts without a handshake.

## Configuration
- **`HWALU_DRAIN_ZSKIP_EN`**
  - Defined: at pop, the starting lane is lowered past leading all-zero lanes above lane 0.
    - The start is the highest non-zero lane ≤ `opcode[1:0]`, else lane 0.
    - Lane 0 is always emitted; `out_last` is still on lane 0.
  - Undefined: always start at `opcode[1:0]`.

## Test plan
- **Muladd, 4 lanes:**
  - Stimulus: push `result`=0x3fe8_07ff_0083_fc03, `opcode`=4'b0011, `out_ready`=1.
  - Response: beats 3fe8, 07ff, 0083, fc03 on consecutive cycles, first beat one cycle after the push edge. `out_last` only on fc03; `out_mode`=00.
- **Dot and complex back-to-back:**
  - Stimulus: push 0x0000_0000_0000_0880 with 4'b0100, next cycle 0x0102_6000_fffc_c000 with 4'b1011.
  - Response: 0880 (last), then 0102, 6000, fffc, c000 (last) with no idle cycle between entries. `out_mode` 01 then 10.
- **Zero-lane skip:**
  - Stimulus: push 0x0000_0000_0003_fc01 with 4'b0011.
  - Response without `HWALU_DRAIN_ZSKIP_EN`: 0000, 0000, 0003, fc01. With it defined: 0003, fc01 (last).
- **Backpressure and overflow:**
  - Stimulus: DEPTH=4, `out_ready`=0, push 6 consecutive results.
  - Response: first entry moves to the shift register and 4 more fill the FIFO. `res_ready`=0 afterwards; the 6th push is dropped and `err_ovf`=1.
  - Then raise `out_ready`: all 5 accepted entries drain in order, with `out_data` stable while stalled.
- **Reserved mode:**
  - Stimulus: push any result with 4'b1100, then 0x…_1234 with 4'b0000.
  - Response: no beats for the first entry and `err_mode`=1; then one beat 1234 with `out_last`=1.
- **Reset mid-stream:**
  - Stimulus: assert `rst`=0 during the second beat of a 4-lane entry, then release.
  - Response: `out_valid`=0 immediately and flags cleared. No stale beats appear after release; the next push streams normally.
